// File: rtl/fetch_unit.sv
// PC generator and fetch queue feeding decode over valid/ready.
// Redirects from execute flush the queue and reload the PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign valid_o = (r_count != '0);
    // Push ignores a same-cycle pop: no ready path reaches the ROM.
    assign w_push  = fetch_en_i & ~w_full & ~redirect_valid_i;
    assign w_pop   = valid_o & ready_i & ~redirect_valid_i;

    assign rom_addr_o = r_pc;
    assign instr_o    = valid_o ? r_ins_mem[r_rd] : NOP;
    assign pc_o       = valid_o ? r_pc_mem[r_rd] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (redirect_valid_i) begin
            r_pc    <= redirect_pc_i & 32'hFFFF_FFFC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + 32'd4;
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr]  <= r_pc;
            r_ins_mem[r_wr] <= rom_instr_i;
        end
    end

endmodule
